skew_in_feeder: RTL

Input-side skew stage of the GEMM systolic array. Accepts unskewed activation rows over a valid/ready handshake and delays lane r by r additional stream steps, producing the diagonal wavefront the PE grid expects. Advances only on CMD_STREAM, in step with the output de-skew stage. Tracks the end of a burst, drains the in-flight wavefront, and pulses `done` when the last row has fully entered the array.

---
 rtl/GEMM_pkg.sv | 17 +
 rtl/skew_lane.sv | 38 +++
 rtl/skew_in_feeder.sv | 104 ++++++++++
 3 files changed

// File: rtl/GEMM_pkg.sv
// Shared GEMM systolic-array types: array command encoding and skew-in FSM states.
package GEMM_pkg;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_LOAD_WEIGHTS,
        CMD_STREAM,
        CMD_FLUSH
    } command_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } skew_in_state_t;

endpackage

// File: rtl/skew_lane.sv
// One skew lane: enable-gated DEPTH-stage shift register carrying data plus a valid tag.
module skew_lane #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid
);

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            tag_q;

    // NOTE: the stage data is reset along with the tags so the array sees clean
    // zeros after reset; non-blocking assignments let every stage read its
    // neighbour's pre-edge value, which is what makes this a shift register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_q <= '0;
            tag_q  <= '0;
        end else if (en) begin
            data_q[0] <= din;
            tag_q[0]  <= din_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign dout       = data_q[DEPTH-1];
    assign dout_valid = tag_q[DEPTH-1];

endmodule

// File: rtl/skew_in_feeder.sv
// Input-side skew stage of the GEMM array: lane r delays rows by r extra stream steps.
// Build option SKEW_IN_ZERO_FILL_EN: bubble slots carry zero data instead of in_data.
module skew_in_feeder
    import GEMM_pkg::*;
#(
    parameter int SA_SIZE         = 8,
    parameter int ACTIVATION_SIZE = 32
) (
    input  logic                                     clk,
    input  logic                                     resetn,
    input  command_t                                 cmd,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]  in_data,
    input  logic                                     in_last,
    output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]  out,
    output logic [SA_SIZE-1:0]                       out_valid,
    output logic                                     busy,
    output logic                                     done
);

    localparam int CNT_W = $clog2(SA_SIZE);
    // Counter value on the drain edge that brings the last row to the final lane.
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(SA_SIZE - 2);

    skew_in_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic done_d;
    logic advance;
    logic accept;
    logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] lane_din;

    assign advance  = (cmd == CMD_STREAM);
    assign in_ready = advance && (state_q != DRAIN);
    assign accept   = in_valid && in_ready;

`ifdef SKEW_IN_ZERO_FILL_EN
    assign lane_din = accept ? in_data : '0;
`else
    assign lane_din = in_data;
`endif

    for (genvar r = 0; r < SA_SIZE; r++) begin : g_lane
        skew_lane #(
            .DEPTH (r + 1),
            .WIDTH (ACTIVATION_SIZE)
        ) u_lane (
            .clk        (clk),
            .resetn     (resetn),
            .en         (advance),
            .din        (lane_din[r]),
            .din_valid  (accept),
            .dout       (out[r]),
            .dout_valid (out_valid[r])
        );
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_last ? DRAIN : STREAM;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (advance) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_PRE_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done    <= done_d;
            busy    <= (state_d != IDLE);
        end
    end

endmodule
